// File: rtl/icache_line_ctrl.sv
// Direct-mapped instruction cache controller with multi-word lines, filled by one AHB-Lite
// incrementing burst per miss; also supports uncached bypass fetches and deferred flush.
module icache_line_ctrl #(
    parameter int unsigned NUM_LINES  = 64,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HBURST,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_data,
    output logic        cpu_ready,
    output logic        cpu_error,
    input  logic        cache_enable,
    input  logic        cache_flush,
    output logic        cache_hit,
    output logic        cache_miss
);
    localparam int unsigned OFF_BITS = $clog2(LINE_WORDS);
    localparam int unsigned IDX_BITS = $clog2(NUM_LINES);
    localparam int unsigned TAG_BITS = 30 - OFF_BITS - IDX_BITS;
    localparam int unsigned CNT_BITS = OFF_BITS + 1;
    localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(LINE_WORDS - 1);
    localparam logic [CNT_BITS-1:0] FULL = CNT_BITS'(LINE_WORDS);
    localparam logic [2:0] BURST = (LINE_WORDS == 16) ? 3'b111 :
                                   (LINE_WORDS == 8)  ? 3'b101 : 3'b011;

    typedef enum logic [2:0] {StIdle, StLookup, StFill, StBypass, StRespond, StFlush} state_e;

    state_e                state_q, state_d;
    logic [31:2]           req_addr_q;
    logic [31:0]           rsp_data_q;
    logic                  rsp_err_q;
    logic [CNT_BITS-1:0]   addr_cnt_q, data_cnt_q;
    logic                  err_seen_q;
    logic                  flush_pending_q;
    logic [NUM_LINES-1:0]  valid_q;
    logic [TAG_BITS-1:0]   tag_mem [NUM_LINES];
    logic [31:0]           data_mem [NUM_LINES*LINE_WORDS];

    logic [TAG_BITS-1:0]   req_tag;
    logic [IDX_BITS-1:0]   req_idx;
    logic [OFF_BITS-1:0]   req_off;
    logic [31:0]           line_base;
    logic                  hit, accept, in_bus, addr_phase, data_phase;
    logic                  issue, beat_ok, beat_err, fill_done;
    logic                  unused_addr_bits;

    assign req_tag   = req_addr_q[31 -: TAG_BITS];
    assign req_idx   = req_addr_q[2+OFF_BITS +: IDX_BITS];
    assign req_off   = req_addr_q[2 +: OFF_BITS];
    assign line_base = {req_addr_q[31:2+OFF_BITS], {(OFF_BITS+2){1'b0}}};
    assign hit       = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign HSIZE  = 3'b010;
    assign HWRITE = 1'b0;

    // Address and data phases overlap; a data phase is outstanding whenever more
    // addresses have been accepted than data beats returned.
    assign in_bus     = (state_q == StFill) || (state_q == StBypass);
    assign addr_phase = in_bus && !err_seen_q &&
                        ((state_q == StFill) ? (addr_cnt_q != FULL) : (addr_cnt_q == '0));
    assign data_phase = in_bus && (addr_cnt_q != data_cnt_q);
    assign issue      = addr_phase && HREADY && !HRESP;
    assign beat_ok    = data_phase && HREADY && !HRESP;
    assign beat_err   = data_phase && HREADY && HRESP;
    assign fill_done  = (state_q == StFill) && beat_ok && (data_cnt_q == LAST);
    assign accept     = (state_q == StIdle) && ((state_d == StLookup) || (state_d == StBypass));

    always_comb begin
        state_d    = state_q;
        HADDR      = line_base;
        HTRANS     = 2'b00;
        HBURST     = 3'b000;
        cpu_data   = 32'h0;
        cpu_ready  = 1'b0;
        cpu_error  = 1'b0;
        cache_hit  = 1'b0;
        cache_miss = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (flush_pending_q || cache_flush) begin
                    state_d = StFlush;
                end else if (cpu_req) begin
                    state_d = cache_enable ? StLookup : StBypass;
                end
            end
            StLookup: begin
                if (hit) begin
                    cache_hit = 1'b1;
                    cpu_ready = 1'b1;
                    cpu_data  = data_mem[{req_idx, req_off}];
                    state_d   = StIdle;
                end else begin
                    cache_miss = 1'b1;
                    state_d    = StFill;
                end
            end
            StFill: begin
                if (addr_phase) begin
                    HTRANS = (addr_cnt_q == '0) ? 2'b10 : 2'b11;
                    HBURST = BURST;
                    HADDR  = {req_addr_q[31:2+OFF_BITS], addr_cnt_q[OFF_BITS-1:0], 2'b00};
                end
                if (beat_err || fill_done) begin
                    state_d = StRespond;
                end
            end
            StBypass: begin
                if (addr_phase) begin
                    HTRANS = 2'b10;
                    HADDR  = {req_addr_q, 2'b00};
                end
                if (beat_err || beat_ok) begin
                    state_d = StRespond;
                end
            end
            StRespond: begin
                cpu_ready = 1'b1;
                cpu_data  = rsp_data_q;
                cpu_error = rsp_err_q;
                state_d   = StIdle;
            end
            StFlush: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q         <= StIdle;
            req_addr_q      <= '0;
            rsp_data_q      <= '0;
            rsp_err_q       <= 1'b0;
            addr_cnt_q      <= '0;
            data_cnt_q      <= '0;
            err_seen_q      <= 1'b0;
            flush_pending_q <= 1'b0;
            valid_q         <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_addr_q <= cpu_addr[31:2];
                addr_cnt_q <= '0;
                data_cnt_q <= '0;
                err_seen_q <= 1'b0;
                rsp_err_q  <= 1'b0;
            end
            if (issue) begin
                addr_cnt_q <= addr_cnt_q + CNT_BITS'(1);
            end
            if (beat_ok) begin
                data_cnt_q <= data_cnt_q + CNT_BITS'(1);
                if ((state_q == StBypass) || (data_cnt_q[OFF_BITS-1:0] == req_off)) begin
                    rsp_data_q <= HRDATA;
                end
            end
            // First cycle of a two-cycle ERROR: stop issuing so HTRANS drops to IDLE.
            if (data_phase && HRESP && !HREADY) begin
                err_seen_q <= 1'b1;
            end
            if (beat_err) begin
                rsp_err_q <= 1'b1;
            end
            if (state_q == StFlush) begin
                valid_q         <= '0;
                flush_pending_q <= 1'b0;
            end else begin
                if (cache_flush && (state_q != StIdle)) begin
                    flush_pending_q <= 1'b1;
                end
                if (beat_err) begin
                    valid_q[req_idx] <= 1'b0;
                end else if (fill_done) begin
                    valid_q[req_idx] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if ((state_q == StFill) && beat_ok) begin
            data_mem[{req_idx, data_cnt_q[OFF_BITS-1:0]}] <= HRDATA;
        end
        if (fill_done) begin
            tag_mem[req_idx] <= req_tag;
        end
    end

endmodule
